// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// MEM pipeline stage: latches the EXE bus, waits for the data-SRAM response,
// aligns and extends load data, and drops responses orphaned by a WB flush.
module mem_stage #(
  parameter int EXE_BUS_W = 173,
  parameter int MEM_BUS_W = 168
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 exe_to_mem_valid,
  input  logic [EXE_BUS_W-1:0] exe_bus,
  output logic                 MEM_allow_in,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 wb_flush,
  input  logic                 WB_allow_in,
  output logic                 mem_to_wb_valid,
  output logic [MEM_BUS_W-1:0] MEMreg_bus,
  output logic [39:0]          MEM_bypass_bus,
  output logic                 mem_ex
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DISCARD} state_t;

  state_t               state_reg, state_next, load_state;
  logic                 valid_reg, valid_next;
  logic [EXE_BUS_W-1:0] exe_bus_reg;
  logic [31:0]          data_buf_reg;

  logic [15:0] ebus;
  logic        ertn_flush;
  logic [79:0] csr_ctrl;
  logic        res_from_csr;
  logic        res_from_mem;
  logic [2:0]  ld_op;
  logic        mem_req;
  logic [31:0] alu_result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] pc;

  logic        in_mem_req;
  logic [15:0] in_ebus;

  logic        mem_ready_go;
  logic        load_fire;
  logic        handoff;
  logic        load_pending;
  logic        rf_we_valid;

  logic [31:0] load_src;
  logic [7:0]  lane [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign {ebus, ertn_flush, csr_ctrl, res_from_csr, res_from_mem, ld_op, mem_req,
          alu_result, rf_we, rf_waddr, pc} = exe_bus_reg;

  assign in_mem_req = exe_bus[70];
  assign in_ebus    = exe_bus[172:157];

  // Handshake
  assign mem_ready_go    = ~valid_reg | ~mem_req | (|ebus) | (state_reg == S_HOLD)
                         | ((state_reg == S_WAIT) & data_sram_data_ok);
  assign mem_to_wb_valid = valid_reg & mem_ready_go & ~wb_flush;
  assign MEM_allow_in    = (state_reg != S_DISCARD)
                         & (~valid_reg | (mem_ready_go & WB_allow_in));
  assign load_fire       = exe_to_mem_valid & MEM_allow_in & ~wb_flush;
  assign handoff         = mem_to_wb_valid & WB_allow_in;

  // Only a memory access without an exception owes a response
  assign load_state = (in_mem_req & ~(|in_ebus)) ? S_WAIT : S_IDLE;

  always_comb begin
    valid_next = valid_reg;
    if (wb_flush)
      valid_next = 1'b0;
    else if (load_fire)
      valid_next = 1'b1;
    else if (handoff)
      valid_next = 1'b0;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (load_fire)
          state_next = load_state;
      end
      S_WAIT: begin
        if (wb_flush)
          state_next = data_sram_data_ok ? S_IDLE : S_DISCARD;
        else if (data_sram_data_ok) begin
          if (load_fire)
            state_next = load_state;
          else if (handoff)
            state_next = S_IDLE;
          else
            state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (wb_flush)
          state_next = S_IDLE;
        else if (load_fire)
          state_next = load_state;
        else if (handoff)
          state_next = S_IDLE;
      end
      S_DISCARD: begin
        if (data_sram_data_ok)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      valid_reg    <= 1'b0;
      exe_bus_reg  <= '0;
      data_buf_reg <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      if (load_fire)
        exe_bus_reg <= exe_bus;
      if ((state_reg == S_WAIT) && data_sram_data_ok)
        data_buf_reg <= data_sram_rdata;
    end
  end

  // Load alignment: byte lanes picked by the low address bits
  assign load_src = (state_reg == S_HOLD) ? data_buf_reg : data_sram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = load_src[8*gi +: 8];
    end
  endgenerate

  assign ld_byte = lane[alu_result[1:0]];
  assign ld_half = alu_result[1] ? load_src[31:16] : load_src[15:0];

  always_comb begin
    case (ld_op[1:0])
      2'b01:   load_data = {{24{~ld_op[2] & ld_byte[7]}}, ld_byte};
      2'b10:   load_data = {{16{~ld_op[2] & ld_half[15]}}, ld_half};
      default: load_data = load_src;
    endcase
  end

  assign final_result = res_from_mem ? load_data : alu_result;

  assign load_pending = valid_reg & res_from_mem & ~mem_ready_go;
  assign rf_we_valid  = valid_reg & rf_we & ~(|ebus);
  assign mem_ex       = valid_reg & ((|ebus) | ertn_flush);

  assign MEMreg_bus     = {ebus, ertn_flush, csr_ctrl, res_from_csr, final_result,
                           rf_we, rf_waddr, pc};
  assign MEM_bypass_bus = {res_from_csr, load_pending, rf_waddr, rf_we_valid, final_result};

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// Bench for mem_stage: directed corner cases plus random traffic, with a
// reference model feeding a scoreboard that a separate monitor drains.
module tb_mem_stage;

  localparam int FR_LSB = 38;

  logic         clk = 1'b0;
  logic         reset;
  logic         exe_to_mem_valid;
  logic [172:0] exe_bus;
  logic         MEM_allow_in;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         wb_flush;
  logic         WB_allow_in;
  logic         mem_to_wb_valid;
  logic [167:0] MEMreg_bus;
  logic [39:0]  MEM_bypass_bus;
  logic         mem_ex;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .exe_to_mem_valid  (exe_to_mem_valid),
    .exe_bus           (exe_bus),
    .MEM_allow_in      (MEM_allow_in),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .wb_flush          (wb_flush),
    .WB_allow_in       (WB_allow_in),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .MEMreg_bus        (MEMreg_bus),
    .MEM_bypass_bus    (MEM_bypass_bus),
    .mem_ex            (mem_ex)
  );

  // Instruction currently offered by EXE
  logic [15:0] i_ebus;
  logic        i_ertn;
  logic [79:0] i_csr;
  logic        i_rfc, i_rfm, i_mreq, i_rfwe;
  logic [2:0]  i_ldop;
  logic [31:0] i_alu, i_pc, i_rdata;
  logic [4:0]  i_waddr;
  int          i_delay;

  assign exe_bus = {i_ebus, i_ertn, i_csr, i_rfc, i_rfm, i_ldop, i_mreq,
                    i_alu, i_rfwe, i_waddr, i_pc};

  typedef struct {
    logic [167:0] memreg;
    logic         ex;
    logic [39:0]  byp;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          accepted = 0;
  bit          owe = 0;
  int          cnt = 0;
  logic [31:0] resp_data = '0;

  task automatic check(string name, logic [167:0] act, logic [167:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Loaded value from the instruction's rules: pick the lane, then extend
  function automatic logic [31:0] load_ext(logic [2:0] op, logic [31:0] addr, logic [31:0] d);
    logic [31:0] v;
    case (op)
      3'b001, 3'b101: begin
        v = (d >> (8 * addr[1:0])) & 32'hFF;
        if (op == 3'b001 && v >= 32'd128) v = v + 32'hFFFFFF00;
      end
      3'b010, 3'b110: begin
        v = (d >> (16 * addr[1])) & 32'hFFFF;
        if (op == 3'b010 && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  task automatic set_instr(logic [15:0] eb, logic mreq, logic rfm, logic [2:0] op,
                           logic [31:0] alu, logic rfwe, logic [4:0] wa, logic [31:0] pc,
                           logic [31:0] rd, int dly);
    i_ebus = eb; i_ertn = 1'b0; i_csr = '0; i_rfc = 1'b0; i_rfm = rfm; i_ldop = op;
    i_mreq = mreq; i_alu = alu; i_rfwe = rfwe; i_waddr = wa; i_pc = pc;
    i_rdata = rd; i_delay = dly;
  endtask

  task automatic gen_instr();
    int kind;
    kind    = $urandom_range(0, 9);
    i_pc    = $urandom & 32'hFFFF_FFFC;
    i_alu   = $urandom;
    i_waddr = 5'($urandom);
    i_rfwe  = 1'($urandom);
    i_csr   = {16'($urandom), $urandom, $urandom};
    i_rfc   = 1'($urandom);
    i_ertn  = ($urandom_range(0, 19) == 0);
    i_ebus  = ($urandom_range(0, 9) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
    i_rdata = $urandom;
    i_delay = $urandom_range(0, 3);
    case ($urandom_range(0, 4))
      0: i_ldop = 3'b000;
      1: i_ldop = 3'b001;
      2: i_ldop = 3'b101;
      3: i_ldop = 3'b010;
      default: i_ldop = 3'b110;
    endcase
    i_mreq = (kind >= 4);
    i_rfm  = (kind >= 4) && (kind <= 7) && (i_ebus == 16'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder drives data_ok, then model bookkeeping at the falling edge
  task automatic settle();
    bit          dok, acc;
    logic [31:0] fin;
    exp_t        e;
    data_sram_data_ok = owe && (cnt == 0) && !reset;
    data_sram_rdata   = data_sram_data_ok ? resp_data : $urandom;
    @(negedge clk);
    dok = data_sram_data_ok;
    acc = exe_to_mem_valid && MEM_allow_in && !wb_flush;
    accepted = acc;
    if (wb_flush) sb_q.delete();
    if (dok) owe = 0;
    else if (owe && cnt > 0) cnt--;
    if (acc) begin
      fin      = i_rfm ? load_ext(i_ldop, i_alu, i_rdata) : i_alu;
      e.memreg = {i_ebus, i_ertn, i_csr, i_rfc, fin, i_rfwe, i_waddr, i_pc};
      e.ex     = (i_ebus != 16'h0) || i_ertn;
      e.byp    = {i_rfc, 1'b0, i_waddr, i_rfwe && (i_ebus == 16'h0), fin};
      sb_q.push_back(e);
      if (i_mreq && i_ebus == 16'h0) begin
        owe = 1; cnt = i_delay; resp_data = i_rdata;
      end
    end
  endtask

  // Monitor: every WB handoff must match the oldest expected instruction
  always @(negedge clk) begin
    exp_t e;
    if (!reset && mem_to_wb_valid && WB_allow_in) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_handoff: got bus %0h want no output", MEMreg_bus);
      end else begin
        e = sb_q.pop_front();
        check("memreg_bus", MEMreg_bus, e.memreg);
        check("mem_ex", mem_ex, e.ex);
        check("bypass_bus", MEM_bypass_bus, e.byp);
      end
    end
  end

  task automatic load_case(string tag, logic [2:0] op, logic [31:0] addr,
                           logic [31:0] rd, logic [31:0] want);
    tick(); set_instr(16'h0, 1'b1, 1'b1, op, addr, 1'b1, 5'd7, 32'h1c000100, rd, 2);
    exe_to_mem_valid = 1; WB_allow_in = 1; settle();
    for (int k = 0; k < 2; k++) begin
      tick(); exe_to_mem_valid = 0; settle();
      check({tag, "_load_pending"}, MEM_bypass_bus[38], 1'b1);
      check({tag, "_stall_allow_in"}, MEM_allow_in, 1'b0);
    end
    tick(); settle();
    check({tag, "_valid"}, mem_to_wb_valid, 1'b1);
    check({tag, "_final"}, MEMreg_bus[FR_LSB +: 32], want);
  endtask

  initial begin
    reset = 1; exe_to_mem_valid = 0; wb_flush = 0; WB_allow_in = 0;
    data_sram_data_ok = 0; data_sram_rdata = '0;
    set_instr(16'h0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_to_wb_valid", mem_to_wb_valid, 1'b0);
    check("rst_allow_in", MEM_allow_in, 1'b1);
    check("rst_bypass", MEM_bypass_bus, 40'h0);
    check("rst_memreg", MEMreg_bus, 168'h0);
    check("rst_mem_ex", mem_ex, 1'b0);
    tick(); reset = 0;

    // ALU instruction passes in one cycle
    tick(); set_instr(16'h0, 1'b0, 1'b0, 3'b000, 32'h12345678, 1'b1, 5'd5, 32'h1c000000, 32'h0, 0);
    exe_to_mem_valid = 1; WB_allow_in = 1; settle();
    tick(); exe_to_mem_valid = 0; settle();
    check("alu_valid", mem_to_wb_valid, 1'b1);
    check("alu_final", MEMreg_bus[FR_LSB +: 32], 32'h12345678);
    check("alu_rf_we_valid", MEM_bypass_bus[32], 1'b1);

    load_case("ld_b", 3'b001, 32'h00001003, 32'h80FF0000, 32'hFFFFFF80);
    load_case("ld_bu", 3'b101, 32'h00001003, 32'h80FF0000, 32'h00000080);

    // ld.hu with WB stalled: result must come from the buffer
    tick(); set_instr(16'h0, 1'b1, 1'b1, 3'b110, 32'h00002002, 1'b1, 5'd9, 32'h1c000200, 32'hABCD1234, 0);
    exe_to_mem_valid = 1; WB_allow_in = 1; settle();
    for (int k = 0; k < 3; k++) begin
      tick(); exe_to_mem_valid = 0; WB_allow_in = 0; settle();
      check("hold_valid", mem_to_wb_valid, 1'b1);
      check("hold_final", MEMreg_bus[FR_LSB +: 32], 32'h0000ABCD);
    end
    tick(); WB_allow_in = 1; settle();
    check("hold_allow_in", MEM_allow_in, 1'b1);
    tick(); settle();
    check("hold_drained", mem_to_wb_valid, 1'b0);

    // Flush while waiting: orphaned response must be absorbed
    tick(); set_instr(16'h0, 1'b1, 1'b1, 3'b000, 32'h00003000, 1'b1, 5'd3, 32'h1c000300, 32'hDEADBEEF, 4);
    exe_to_mem_valid = 1; settle();
    tick(); exe_to_mem_valid = 0; wb_flush = 1; settle();
    check("flush_to_wb_valid", mem_to_wb_valid, 1'b0);
    tick(); wb_flush = 0;
    set_instr(16'h0, 1'b0, 1'b0, 3'b000, 32'h0BADF00D, 1'b1, 5'd4, 32'h1c000304, 32'h0, 0);
    exe_to_mem_valid = 1;
    for (int k = 0; k < 10 && owe; k++) begin
      settle();
      check("discard_allow_in", MEM_allow_in, 1'b0);
      if (owe) tick();
    end
    if (owe) begin
      failures++;
      $display("FAIL discard_timeout: got no data_ok want response within 10 cycles");
    end
    tick(); settle();
    check("post_discard_allow_in", MEM_allow_in, 1'b1);
    tick(); exe_to_mem_valid = 0; settle();

    // Exception instruction passes through with writes suppressed
    tick(); set_instr(16'h0040, 1'b0, 1'b0, 3'b000, 32'h55555555, 1'b1, 5'd6, 32'h1c000400, 32'h0, 0);
    exe_to_mem_valid = 1; settle();
    tick(); exe_to_mem_valid = 0; settle();
    check("exc_valid", mem_to_wb_valid, 1'b1);
    check("exc_mem_ex", mem_ex, 1'b1);
    check("exc_rf_we_valid", MEM_bypass_bus[32], 1'b0);
    check("exc_ebus", MEMreg_bus[167:152], 16'h0040);

    // Asynchronous reset in the middle of a wait
    tick(); set_instr(16'h0, 1'b1, 1'b1, 3'b000, 32'h00004000, 1'b1, 5'd8, 32'h1c000500, 32'h13579BDF, 5);
    exe_to_mem_valid = 1; settle();
    tick(); exe_to_mem_valid = 0; settle();
    check("wait_load_pending", MEM_bypass_bus[38], 1'b1);
    tick(); reset = 1; #1;
    check("arst_to_wb_valid", mem_to_wb_valid, 1'b0);
    check("arst_allow_in", MEM_allow_in, 1'b1);
    check("arst_memreg", MEMreg_bus, 168'h0);
    check("arst_bypass", MEM_bypass_bus, 40'h0);
    check("arst_mem_ex", mem_ex, 1'b0);
    sb_q.delete(); owe = 0; data_sram_data_ok = 0;
    @(negedge clk);
    tick(); reset = 0;
    tick(); set_instr(16'h0, 1'b0, 1'b0, 3'b000, 32'hCAFEF00D, 1'b1, 5'd11, 32'h1c000600, 32'h0, 0);
    exe_to_mem_valid = 1; WB_allow_in = 1; settle();
    tick(); exe_to_mem_valid = 0; settle();
    check("post_rst_valid", mem_to_wb_valid, 1'b1);
    check("post_rst_final", MEMreg_bus[FR_LSB +: 32], 32'hCAFEF00D);

    // Random traffic with WB stalls and flushes
    accepted = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (!exe_to_mem_valid || accepted) begin
        if ($urandom_range(0, 3) != 0) begin
          gen_instr();
          exe_to_mem_valid = 1;
        end else begin
          exe_to_mem_valid = 0;
        end
      end
      WB_allow_in = ($urandom_range(0, 9) < 7);
      wb_flush    = ($urandom_range(0, 29) == 0);
      settle();
    end

    tick(); exe_to_mem_valid = 0; wb_flush = 0; WB_allow_in = 1;
    for (int c = 0; c < 50 && (sb_q.size() != 0 || owe); c++) begin
      settle();
      tick();
    end
    check("drain_empty", 168'(sb_q.size()), 168'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got no completion want finish before 2ms");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EXE and WB. It latches the EXE→MEM bus through a valid/allow-in handshake and waits for the data-SRAM response of an issued load or store. It aligns and extends load data, then presents the packed MEMreg bus and a valid to WB. It also absorbs responses orphaned by a WB flush, and exports a bypass bus and an exception flag upstream.

## Interface
Parameters:
- EXE_BUS_W, 173, width of exe_bus.
- MEM_BUS_W, 168, width of MEMreg_bus.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-high.
- exe_to_mem_valid, in, 1, EXE holds a valid, ready instruction.
- exe_bus, in, 173, {ebus[15:0], ertn_flush, csr_ctrl[79:0], res_from_csr, res_from_mem, ld_op[2:0], mem_req, alu_result[31:0], rf_we, rf_waddr[4:0], pc[31:0]}, MSB first.
- MEM_allow_in, out, 1, stage can accept from EXE this cycle.
- data_sram_data_ok, in, 1, response for the oldest outstanding request.
- data_sram_rdata, in, 32, read data qualified by data_ok.
- wb_flush, in, 1, WB is taking an exception or ertn this cycle.
- WB_allow_in, in, 1, WB accepts this cycle.
- mem_to_wb_valid, out, 1, MEMreg_bus valid for WB.
- MEMreg_bus, out, 168, {ebus, ertn_flush, csr_ctrl, res_from_csr, final_result[31:0], rf_we, rf_waddr, pc}.
- MEM_bypass_bus, out, 40, {res_from_csr, load_pending, rf_waddr, rf_we_valid, final_result}.
- mem_ex, out, 1, valid instruction here carries an exception or ertn; EXE must suppress store issue.

## Operation
- Pipeline register: valid_r plus all exe_bus fields, plus a 32-bit data buffer.
- Load rule: on exe_to_mem_valid & MEM_allow_in, latch exe_bus and set valid_r = 1.
- Handoff rule: on mem_to_wb_valid & WB_allow_in with no new load, clear valid_r.
- On wb_flush, clear valid_r at the next edge and ignore any same-cycle load from EXE.
- FSM states:
  - IDLE: no outstanding response.
  - WAIT: request issued, awaiting data_ok.
  - HOLD: data buffered, waiting for WB.
  - DISCARD: orphaned response pending after a flush.
- IDLE/HOLD/handoff → WAIT on a load with mem_req = 1 and ebus = 0; → IDLE on a load with mem_req = 0.
- WAIT + data_ok: capture rdata into the buffer. Go to IDLE if the instruction hands off the same cycle, else go to HOLD.
- WAIT + wb_flush without data_ok → DISCARD. WAIT + wb_flush with data_ok → IDLE, data dropped.
- HOLD + wb_flush → IDLE.
- DISCARD + data_ok → IDLE, data dropped. MEM_allow_in = 0 throughout DISCARD.
- MEM_ready_go = ~valid_r | ~mem_req | |ebus | (state == HOLD) | (state == WAIT & data_ok).
- mem_to_wb_valid = valid_r & MEM_ready_go & ~wb_flush.
- MEM_allow_in = (state != DISCARD) & (~valid_r | (MEM_ready_go & WB_allow_in)).
- Load data source: the buffer in HOLD, data_sram_rdata in WAIT.
- Load byte/half lane is selected by alu_result[1:0]. ld_op encoding:
  - 000: word.
  - 001: byte, sign-extended.
  - 101: byte, zero-extended.
  - 010: half, sign-extended; lane from alu_result[1].
  - 110: half, zero-extended; lane from alu_result[1].
- final_result = res_from_mem ? aligned load data : alu_result.
- load_pending = valid_r & res_from_mem & ~MEM_ready_go.
- rf_we_valid = valid_r & rf_we & ~|ebus.
- mem_ex = valid_r & (|ebus | ertn_flush).
- MEMreg_bus fields other than final_result pass through unchanged.

## Timing
- Reset: valid_r = 0, state IDLE, buffer = 0, all latched fields = 0.
- Outputs while in reset: mem_to_wb_valid = 0, MEM_allow_in = 1, MEM_bypass_bus = 0, MEMreg_bus = 0, mem_ex = 0.
- Non-memory instruction: 1 cycle in stage.
- Load/store: stays until data_ok; MEMreg_bus valid the same cycle data_ok is seen.
- Back-to-back: a new instruction may be latched on the same edge the current one hands off.
- Response ordering: at most one outstanding response is tracked. EXE must not issue a request while MEM_allow_in = 0.
- Reset asserted mid-WAIT or mid-DISCARD: return to IDLE immediately. The memory side is reset together, so no response is owed.

## Test plan
- ALU instruction: pc = 0x1c000000, alu_result = 0x12345678, rf_waddr = 5 → one cycle later mem_to_wb_valid = 1, final_result = 0x12345678, bypass rf_we_valid = 1.
- ld.b at addr 0x...3, data_ok 2 cycles after latch, rdata = 0x80FF0000 → stalls 2 cycles (load_pending = 1, MEM_allow_in = 0), then final_result = 0xFFFFFF80. Same with ld.bu → 0x00000080.
- ld.hu at addr 0x...2, data_ok with WB_allow_in = 0 for 3 cycles → state HOLD, buffered; handoff when WB_allow_in = 1 gives final_result = 0x0000ABCD for rdata = 0xABCD1234.
- Load in WAIT plus wb_flush pulse → mem_to_wb_valid = 0, state DISCARD, MEM_allow_in = 0. A later data_ok → IDLE, MEM_allow_in = 1, rdata never appears on MEMreg_bus.
- exe_bus with ebus = 0x0040 and mem_req = 0 → passes in 1 cycle, mem_ex = 1, rf_we_valid = 0, ebus unchanged on MEMreg_bus.
- Reset asserted asynchronously mid-WAIT → outputs at reset values before the next edge; a following ALU instruction completes normally.
